// File: rtl/mac_pe_vec_if.sv
// Beat/result bus of the vector MAC PE: feeder-side controls, beat handshake,
// result handshake and progress counter.
interface mac_pe_vec_if #(
    parameter int LANES     = 4,
    parameter int W_WIDTH   = 4,
    parameter int A_WIDTH   = 8,
    parameter int ACC_WIDTH = 21,
    parameter int VEC_LEN   = 64
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);

    logic                         en;
    logic                         clear;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*W_WIDTH-1:0]     weight;
    logic [LANES*A_WIDTH-1:0]     activation;
    logic                         acc;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*ACC_WIDTH-1:0]   out_result;
    logic [LANES-1:0]             out_sat;
    logic [CNT_W-1:0]             beat_cnt;

    modport master (
        output en, clear, in_valid, weight, activation, acc, out_ready,
        input  in_ready, out_valid, out_result, out_sat, beat_cnt
    );

    modport slave (
        input  en, clear, in_valid, weight, activation, acc, out_ready,
        output in_ready, out_valid, out_result, out_sat, beat_cnt
    );
endinterface

// File: rtl/mac_pe_vec.sv
// LANES-wide signed weight x activation MAC with a registered product stage,
// optional saturating accumulation and a valid/ready result port.
module mac_pe_vec #(
    parameter int LANES     = 4,
    parameter int W_WIDTH   = 4,
    parameter int A_WIDTH   = 8,
    parameter int ACC_WIDTH = 21,
    parameter int VEC_LEN   = 64,
    parameter bit SAT_EN    = 1'b1
) (
    input logic         clk,
    input logic         rst,
    mac_pe_vec_if.slave bus
);
    // state | meaning
    // ACCUM | accepting beats; previous beat's product is added each enabled edge
    // DRAIN | vector closed; last pending product added, result captured
    // HOLD  | result presented until out_ready

    localparam int P_WIDTH = W_WIDTH + A_WIDTH;
    localparam int SUM_W   = ACC_WIDTH + 1;
    localparam int CNT_W   = $clog2(VEC_LEN + 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t                       state;
    logic signed [ACC_WIDTH-1:0]  acc_q    [LANES];
    logic signed [P_WIDTH-1:0]    prod_q   [LANES];
    logic                         prod_v;
    logic [CNT_W-1:0]             beat_q;
    logic [LANES-1:0]             sat_q;
    logic                         out_valid_q;
    logic [LANES*ACC_WIDTH-1:0]   result_q;

    logic signed [P_WIDTH-1:0]    prod_c   [LANES];
    logic signed [SUM_W-1:0]      sum_w    [LANES];
    logic signed [ACC_WIDTH-1:0]  acc_nxt  [LANES];
    logic [LANES-1:0]             ovf;
    logic                         in_ready_c;
    logic                         accept;
    logic                         last_beat;

    assign in_ready_c = bus.en & (state == ACCUM) & ~rst;
    assign accept     = bus.in_valid & in_ready_c;
    assign last_beat  = accept & (beat_q == LAST_BEAT);

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_sat    = sat_q;
    assign bus.beat_cnt   = beat_q;

    // One extra sum bit exposes overflow as a mismatch of the top two bits.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = P_WIDTH'($signed(bus.weight[i*W_WIDTH +: W_WIDTH]))
                      * P_WIDTH'($signed(bus.activation[i*A_WIDTH +: A_WIDTH]));
            sum_w[i]  = SUM_W'(acc_q[i]) + SUM_W'(prod_q[i]);
            ovf[i]    = sum_w[i][ACC_WIDTH] ^ sum_w[i][ACC_WIDTH-1];
            if (SAT_EN && ovf[i])
                acc_nxt[i] = sum_w[i][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            else
                acc_nxt[i] = sum_w[i][ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state       <= ACCUM;
            prod_v      <= 1'b0;
            beat_q      <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            unique case (state)
                ACCUM: begin
                    if (bus.en) begin
                        if (prod_v) begin
                            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_nxt[i];
                            if (SAT_EN) sat_q <= sat_q | ovf;
                        end
                        prod_v <= accept;
                        if (accept) begin
                            for (int i = 0; i < LANES; i++) prod_q[i] <= prod_c[i];
                            beat_q <= beat_q + CNT_W'(1);
                        end
                        if (bus.acc || last_beat) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.en) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (prod_v) acc_q[i] <= acc_nxt[i];
                            result_q[i*ACC_WIDTH +: ACC_WIDTH] <= prod_v ? acc_nxt[i] : acc_q[i];
                        end
                        if (prod_v && SAT_EN) sat_q <= sat_q | ovf;
                        prod_v      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                        beat_q      <= '0;
                        sat_q       <= '0;
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_pe_vec.sv
// Directed bench for mac_pe_vec: three instances (21-bit saturating, 16-bit
// saturating, 16-bit wrapping) share one stimulus and one behavioural model.
module tb_mac_pe_vec;
    localparam int LANES   = 4;
    localparam int W_WIDTH = 4;
    localparam int A_WIDTH = 8;
    localparam int VEC_LEN = 64;
    localparam int CNT_W   = $clog2(VEC_LEN + 1);
    localparam int ND      = 3;

    function automatic int cfg_w(input int d);
        return (d == 0) ? 21 : 16;
    endfunction
    function automatic bit cfg_sat(input int d);
        return d != 2;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, clear = 1'b0, in_valid = 1'b0, acc_req = 1'b0, out_ready = 1'b0;
    int   tw [LANES];
    int   ta [LANES];
    logic [LANES*W_WIDTH-1:0] wbus;
    logic [LANES*A_WIDTH-1:0] abus;

    always #5 clk = ~clk;

    always_comb begin
        wbus = '0;
        abus = '0;
        for (int l = 0; l < LANES; l++) begin
            wbus[l*W_WIDTH +: W_WIDTH] = W_WIDTH'(tw[l]);
            abus[l*A_WIDTH +: A_WIDTH] = A_WIDTH'(ta[l]);
        end
    end

    mac_pe_vec_if #(.LANES(LANES), .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .ACC_WIDTH(21), .VEC_LEN(VEC_LEN)) i0 ();
    mac_pe_vec_if #(.LANES(LANES), .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .ACC_WIDTH(16), .VEC_LEN(VEC_LEN)) i1 ();
    mac_pe_vec_if #(.LANES(LANES), .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .ACC_WIDTH(16), .VEC_LEN(VEC_LEN)) i2 ();

    assign i0.en = en;  assign i0.clear = clear;  assign i0.in_valid = in_valid;  assign i0.acc = acc_req;
    assign i0.weight = wbus;  assign i0.activation = abus;  assign i0.out_ready = out_ready;
    assign i1.en = en;  assign i1.clear = clear;  assign i1.in_valid = in_valid;  assign i1.acc = acc_req;
    assign i1.weight = wbus;  assign i1.activation = abus;  assign i1.out_ready = out_ready;
    assign i2.en = en;  assign i2.clear = clear;  assign i2.in_valid = in_valid;  assign i2.acc = acc_req;
    assign i2.weight = wbus;  assign i2.activation = abus;  assign i2.out_ready = out_ready;

    mac_pe_vec #(.LANES(LANES), .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .ACC_WIDTH(21), .VEC_LEN(VEC_LEN), .SAT_EN(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(i0));
    mac_pe_vec #(.LANES(LANES), .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .ACC_WIDTH(16), .VEC_LEN(VEC_LEN), .SAT_EN(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(i1));
    mac_pe_vec #(.LANES(LANES), .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .ACC_WIDTH(16), .VEC_LEN(VEC_LEN), .SAT_EN(1'b0))
        u2 (.clk(clk), .rst(rst), .bus(i2));

    logic             ir [ND];
    logic             ov [ND];
    logic [CNT_W-1:0] bc [ND];
    logic [LANES-1:0] os [ND];
    longint           rl [ND][LANES];

    always_comb begin
        ir[0] = i0.in_ready;  ov[0] = i0.out_valid;  bc[0] = i0.beat_cnt;  os[0] = i0.out_sat;
        ir[1] = i1.in_ready;  ov[1] = i1.out_valid;  bc[1] = i1.beat_cnt;  os[1] = i1.out_sat;
        ir[2] = i2.in_ready;  ov[2] = i2.out_valid;  bc[2] = i2.beat_cnt;  os[2] = i2.out_sat;
        for (int l = 0; l < LANES; l++) begin
            rl[0][l] = longint'($signed(i0.out_result[l*21 +: 21]));
            rl[1][l] = longint'($signed(i1.out_result[l*16 +: 16]));
            rl[2][l] = longint'($signed(i2.out_result[l*16 +: 16]));
        end
    end

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Behavioural model: mode 0 collecting, 1 closing, 2 presenting. Sums are
    // accumulated at acceptance time in beat order with plain integer arithmetic.
    int     m_mode = 0;
    int     m_beats = 0;
    bit     m_take;
    longint m_sum  [ND][LANES];
    bit     m_sat  [ND][LANES];
    longint m_res  [ND][LANES];
    bit     m_rsat [ND][LANES];

    function automatic bit exp_ready();
        return en && !rst && (m_mode == 0);
    endfunction

    always @(posedge clk) begin : model
        longint s, lim;
        m_take = exp_ready() && in_valid;
        if (rst || clear) begin
            m_mode = 0;
            m_beats = 0;
            for (int d = 0; d < ND; d++)
                for (int l = 0; l < LANES; l++) begin
                    m_sum[d][l] = 0; m_sat[d][l] = 0; m_res[d][l] = 0; m_rsat[d][l] = 0;
                end
        end else if (m_mode == 0) begin
            if (en) begin
                if (m_take) begin
                    for (int d = 0; d < ND; d++)
                        for (int l = 0; l < LANES; l++) begin
                            lim = longint'(1) << (cfg_w(d) - 1);
                            s = m_sum[d][l] + longint'(tw[l] * ta[l]);
                            if (cfg_sat(d)) begin
                                if (s > lim - 1) begin s = lim - 1; m_sat[d][l] = 1; end
                                else if (s < -lim) begin s = -lim; m_sat[d][l] = 1; end
                            end else begin
                                s = s & (2 * lim - 1);
                                if (s >= lim) s = s - 2 * lim;
                            end
                            m_sum[d][l] = s;
                        end
                    m_beats++;
                end
                if (acc_req || (m_take && m_beats == VEC_LEN)) m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (en) begin
                m_mode = 2;
                for (int d = 0; d < ND; d++)
                    for (int l = 0; l < LANES; l++) begin
                        m_res[d][l] = m_sum[d][l]; m_rsat[d][l] = m_sat[d][l];
                    end
            end
        end else if (out_ready) begin
            m_mode = 0;
            m_beats = 0;
            for (int d = 0; d < ND; d++)
                for (int l = 0; l < LANES; l++) begin
                    m_sum[d][l] = 0; m_sat[d][l] = 0;
                end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("in_ready[u%0d]", d), ir[d], exp_ready());
                chk($sformatf("out_valid[u%0d]", d), ov[d], m_mode == 2);
                chk($sformatf("beat_cnt[u%0d]", d), bc[d], m_beats);
                if (m_mode == 2)
                    for (int l = 0; l < LANES; l++) begin
                        chk($sformatf("result[u%0d][%0d]", d, l), rl[d][l], m_res[d][l]);
                        chk($sformatf("sat[u%0d][%0d]", d, l), os[d][l], m_rsat[d][l]);
                    end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int w, input int a);
        for (int l = 0; l < LANES; l++) begin tw[l] = w; ta[l] = a; end
    endtask

    task automatic send(input int n, input bit flush_last);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            acc_req  = flush_last && (k == n - 1);
            tick();
        end
        in_valid = 1'b0;
        acc_req  = 1'b0;
    endtask

    initial begin
        set_all(0, 0);
        tick();
        tick();
        chk_on = 1'b1;
        chk("rst_in_ready", ir[0], 0);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_beat_cnt", bc[0], 0);
        chk("rst_result", rl[0][0], 0);
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        #1;
        chk("ready_after_rst", ir[0], 1);

        // full vector with an enable gap holding in_valid high
        set_all(7, 127);
        send(30, 1'b0);
        en = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        chk("gap_beat_cnt", bc[0], 30);
        en = 1'b1; in_valid = 1'b0;
        send(34, 1'b0);
        chk("full_beat_cnt", bc[0], 64);
        chk("full_valid_k1", ov[0], 0);
        tick();
        chk("full_valid_k2", ov[0], 1);
        for (int l = 0; l < LANES; l++) chk("full_lane", rl[0][l], 56896);
        chk("full_sat", os[0], 0);
        tick();

        // saturation versus wrap on the 16-bit instances
        tw[0] = -8; ta[0] = -128;
        tw[1] = -8; ta[1] = 127;
        tw[2] = 1;  ta[2] = 1;
        tw[3] = 0;  ta[3] = 0;
        send(64, 1'b0);
        tick();
        chk("sat_lane0", rl[1][0], 32767);
        chk("sat_lane1", rl[1][1], -32768);
        chk("sat_lane2", rl[1][2], 64);
        chk("sat_flags", os[1], 4'b0011);
        chk("wrap_lane0", rl[2][0], 0);
        chk("wrap_lane1", rl[2][1], 512);
        chk("wrap_flags", os[2], 0);
        chk("wide_lane0", rl[0][0], 65536);
        tick();

        // early flush on the 10th beat, then a flush with no beats
        set_all(3, -5);
        send(10, 1'b1);
        chk("flush_beat_cnt", bc[0], 10);
        tick();
        for (int l = 0; l < LANES; l++) chk("flush_lane", rl[0][l], -150);
        tick();
        acc_req = 1'b1;
        tick();
        acc_req = 1'b0;
        tick();
        chk("empty_valid", ov[0], 1);
        for (int l = 0; l < LANES; l++) chk("empty_lane", rl[0][l], 0);
        tick();

        // output backpressure with beats waiting
        out_ready = 1'b0;
        set_all(2, 3);
        send(64, 1'b0);
        tick();
        set_all(1, 2);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", ov[0], 1);
            chk("bp_result", rl[0][1], 384);
            chk("bp_in_ready", ir[0], 0);
            chk("bp_beat_cnt", bc[0], 64);
            tick();
        end
        out_ready = 1'b1;
        tick();
        send(64, 1'b0);
        tick();
        for (int l = 0; l < LANES; l++) chk("after_bp_lane", rl[0][l], 128);
        tick();

        // soft clear mid-vector
        set_all(5, 5);
        send(20, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_beat_cnt", bc[0], 0);
        set_all(1, 1);
        send(64, 1'b0);
        tick();
        for (int l = 0; l < LANES; l++) chk("after_clear_lane", rl[0][l], 64);
        tick();

        // reset while holding a saturated result
        out_ready = 1'b0;
        set_all(1, 1);
        tw[0] = -8; ta[0] = -128;
        send(40, 1'b1);
        tick();
        chk("hold_valid", ov[1], 1);
        chk("hold_sat", os[1], 4'b0001);
        rst = 1'b1;
        #1;
        chk("rst_hold_in_ready", ir[0], 0);
        tick();
        chk("rst_hold_valid", ov[1], 0);
        chk("rst_hold_result", rl[1][0], 0);
        chk("rst_hold_sat", os[1], 0);
        chk("rst_hold_in_ready2", ir[1], 0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", ir[1], 1);
        tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
